core_run_trace_ctrl: RTL and testbench

Run controller and instruction-trace buffer for the single-cycle RISC-V core.
- Sequences the core's active-low reset.
- Runs the core for a bounded number of cycles, or until a halt opcode is decoded.
- Captures the core's per-cycle decoded fields (immediate, two register indices, funct3, opcode) into a FIFO for readout by a host or bench.
- Generalises the fixed reset-then-run-N-cycles bring-up sequence into parametrised, synthesizable hardware with halt detection and trace capture.

---
 rtl/core_run_trace_ctrl_if.sv | 35 +++
 rtl/core_run_trace_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_core_run_trace_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_trace_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : core_run_trace_ctrl_if
// Brief  : Trace FIFO readout port for the core run/trace controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface core_run_trace_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int TC_W   = 4
);
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [TC_W-1:0]   trace_count;
    logic              overflow;

    modport master (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  trace_count,
        input  overflow
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output trace_count,
        output overflow
    );
endinterface

`default_nettype wire

// File: rtl/core_run_trace_ctrl.sv
//------------------------------------------------------------------------------
// Module : core_run_trace_ctrl
// Brief  : Core reset sequencer, bounded run with halt detection, trace FIFO.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module core_run_trace_ctrl #(
    parameter int              RESET_CYCLES = 2,
    parameter int              MAX_CYCLES   = 5,
    parameter int              TRACE_DEPTH  = 8,
    parameter int              IMM_W        = 12,
    parameter int              REG_W        = 5,
    parameter int              F3_W         = 3,
    parameter int              OP_W         = 7,
    parameter logic [OP_W-1:0] HALT_OPCODE  = 7'h73,
    parameter int              CNT_W        = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    output logic                  core_rst_n,
    input  wire logic [IMM_W-1:0] tr_imm,
    input  wire logic [REG_W-1:0] tr_rs,
    input  wire logic [REG_W-1:0] tr_rd,
    input  wire logic [F3_W-1:0]  tr_f3,
    input  wire logic [OP_W-1:0]  tr_op,
    output logic                  running,
    output logic                  done,
    output logic                  halted,
    output logic                  timeout,
    output logic [CNT_W-1:0]      cycle_count,
    core_run_trace_ctrl_if.slave  rd_if
);

    localparam int c_data_w    = IMM_W + 2*REG_W + F3_W + OP_W;
    localparam int c_addr_w    = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int c_tc_w      = c_addr_w + 1;
    localparam int c_rst_cnt_w = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [c_rst_cnt_w-1:0] c_rst_last = c_rst_cnt_w'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_max_last = CNT_W'(MAX_CYCLES - 1);
    localparam logic [c_tc_w-1:0]      c_depth    = c_tc_w'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_rst_cnt_w-1:0]  r_rst_cnt;
    logic                    r_core_rst_n;
    logic                    r_running;
    logic                    r_done;
    logic                    r_halted;
    logic                    r_timeout;
    logic [CNT_W-1:0]        r_cycle_count;

    logic [c_data_w-1:0]     r_mem [TRACE_DEPTH];
    logic [c_addr_w-1:0]     r_wr_ptr;
    logic [c_addr_w-1:0]     r_rd_ptr;
    logic [c_tc_w-1:0]       r_count;
    logic [c_data_w-1:0]     r_rd_data;
    logic                    r_rd_valid;
    logic                    r_overflow;

    logic                    w_clear;
    logic                    w_push;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_wr;
    logic                    w_drop;
    logic                    w_halt;
    logic                    w_last;
    logic [CNT_W-1:0]        w_cc_inc;
    logic [c_data_w-1:0]     w_entry;

    assign w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_push   = (r_state == ST_RUN);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_depth);
    // A start discards unread trace, so a coincident pop is suppressed.
    assign w_pop    = rd_if.rd_en && !w_empty && !w_clear;
    assign w_wr     = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_halt   = (tr_op == HALT_OPCODE);
    assign w_last   = (r_cycle_count == c_max_last);
    assign w_cc_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_entry  = {tr_imm, tr_rs, tr_rd, tr_f3, tr_op};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_rst_cnt     <= '0;
            r_core_rst_n  <= 1'b0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_RESET;
                        r_rst_cnt     <= '0;
                        r_done        <= 1'b0;
                        r_halted      <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt == c_rst_last) begin
                        r_state      <= ST_RUN;
                        r_core_rst_n <= 1'b1;
                        r_running    <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cycle_count <= w_cc_inc;
                    // Halt takes precedence over an expiring budget.
                    if (w_halt || w_last) begin
                        r_state      <= ST_DONE;
                        r_core_rst_n <= 1'b0;
                        r_running    <= 1'b0;
                        r_done       <= 1'b1;
                        r_halted     <= w_halt;
                        r_timeout    <= !w_halt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // When full, a same-cycle pop reads the old slot before it is rewritten.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign core_rst_n        = r_core_rst_n;
    assign running           = r_running;
    assign done              = r_done;
    assign halted            = r_halted;
    assign timeout           = r_timeout;
    assign cycle_count       = r_cycle_count;
    assign rd_if.rd_data     = r_rd_data;
    assign rd_if.rd_valid    = r_rd_valid;
    assign rd_if.trace_count = r_count;
    assign rd_if.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_core_run_trace_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_core_run_trace_ctrl
// Brief  : Scoreboard bench: default instance plus a 4-deep / 6-cycle instance.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_run_trace_ctrl;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic [11:0] tr_imm;
    logic [4:0]  tr_rs, tr_rd;
    logic [2:0]  tr_f3;
    logic [6:0]  tr_op;

    logic        crn_a, run_a, done_a, halt_a, tmo_a;
    logic        crn_b, run_b, done_b, halt_b, tmo_b;
    logic [15:0] cc_a, cc_b;

    int total = 0;
    int bad   = 0;
    int cur_depth;
    int hi;
    logic [31:0] mdl   [$];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic [31:0] last_exp;
    logic [31:0] mon_e_a, mon_e_b;

    core_run_trace_ctrl_if #(.DATA_W(32), .TC_W(4)) if_a ();
    core_run_trace_ctrl_if #(.DATA_W(32), .TC_W(3)) if_b ();

    core_run_trace_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .core_rst_n(crn_a),
        .tr_imm(tr_imm), .tr_rs(tr_rs), .tr_rd(tr_rd), .tr_f3(tr_f3), .tr_op(tr_op),
        .running(run_a), .done(done_a), .halted(halt_a), .timeout(tmo_a),
        .cycle_count(cc_a), .rd_if(if_a)
    );

    core_run_trace_ctrl #(.TRACE_DEPTH(4), .MAX_CYCLES(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .core_rst_n(crn_b),
        .tr_imm(tr_imm), .tr_rs(tr_rs), .tr_rd(tr_rd), .tr_f3(tr_f3), .tr_op(tr_op),
        .running(run_b), .done(done_b), .halted(halt_b), .timeout(tmo_b),
        .cycle_count(cc_b), .rd_if(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic crn(input int sel);
        return (sel == 0) ? crn_a : crn_b;
    endfunction

    task automatic chk_status(input int sel, input string tag, input logic e_done, input logic e_halt,
                              input logic e_tmo, input logic e_run, input int e_cc, input int e_tc,
                              input logic e_ovf);
        logic d, h, t, r, o;
        int   cc, tc;
        if (sel == 0) begin
            d = done_a; h = halt_a; t = tmo_a; r = run_a; o = if_a.overflow;
            cc = int'(cc_a); tc = int'(if_a.trace_count);
        end else begin
            d = done_b; h = halt_b; t = tmo_b; r = run_b; o = if_b.overflow;
            cc = int'(cc_b); tc = int'(if_b.trace_count);
        end
        chk({tag, "_done"}, 32'(d), 32'(e_done));
        chk({tag, "_halted"}, 32'(h), 32'(e_halt));
        chk({tag, "_timeout"}, 32'(t), 32'(e_tmo));
        chk({tag, "_running"}, 32'(r), 32'(e_run));
        chk({tag, "_cycle_count"}, 32'(cc), 32'(e_cc));
        chk({tag, "_trace_count"}, 32'(tc), 32'(e_tc));
        chk({tag, "_overflow"}, 32'(o), 32'(e_ovf));
    endtask

    // One RUN cycle: drive trace fields, update model, optionally pop alongside.
    task automatic run_cycle(input int sel, input int k, input bit halt, input bit pop);
        logic [31:0] e;
        tr_imm = 12'(12'h100 + k);
        tr_rs  = 5'(k);
        tr_rd  = 5'(31 - k);
        tr_f3  = 3'(k);
        tr_op  = halt ? 7'h73 : 7'h13;
        e = {tr_imm, tr_rs, tr_rd, tr_f3, tr_op};
        if (pop) begin
            if (mdl.size() > 0) begin
                last_exp = mdl.pop_front();
                if (sel == 0) exp_a.push_back(last_exp);
                else          exp_b.push_back(last_exp);
            end
            if (sel == 0) if_a.rd_en = 1'b1;
            else          if_b.rd_en = 1'b1;
        end
        if (mdl.size() < cur_depth) mdl.push_back(e);
        tick();
        if_a.rd_en = 1'b0;
        if_b.rd_en = 1'b0;
    endtask

    // Start pulse, reset phase, then n RUN cycles; hi counts core_rst_n-high samples.
    task automatic do_run(input int sel, input int n, input int halt_at, input int pop_at,
                          output int hi_cnt);
        hi_cnt = 0;
        mdl.delete();
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        if (crn(sel)) hi_cnt++;
        tick();
        if (crn(sel)) hi_cnt++;
        tick();
        if (crn(sel)) hi_cnt++;
        for (int k = 1; k <= n; k++) begin
            run_cycle(sel, k, k == halt_at, k == pop_at);
            if (crn(sel)) hi_cnt++;
        end
    endtask

    task automatic pop_entry(input int sel);
        bit have;
        have = (mdl.size() > 0);
        if (have) begin
            last_exp = mdl.pop_front();
            if (sel == 0) exp_a.push_back(last_exp);
            else          exp_b.push_back(last_exp);
        end
        if (sel == 0) if_a.rd_en = 1'b1;
        else          if_b.rd_en = 1'b1;
        tick();
        if_a.rd_en = 1'b0;
        if_b.rd_en = 1'b0;
        if (!have) begin
            chk("empty_rd_valid", 32'((sel == 0) ? if_a.rd_valid : if_b.rd_valid), 32'd0);
            chk("empty_rd_data", (sel == 0) ? if_a.rd_data : if_b.rd_data, last_exp);
        end
    endtask

    always @(negedge clk) begin
        if (if_a.rd_valid === 1'b1) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_a: got %0h expected no valid", if_a.rd_data);
            end else begin
                mon_e_a = exp_a.pop_front();
                chk("pop_a", if_a.rd_data, mon_e_a);
            end
        end
        if (if_b.rd_valid === 1'b1) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_b: got %0h expected no valid", if_b.rd_data);
            end else begin
                mon_e_b = exp_b.pop_front();
                chk("pop_b", if_b.rd_data, mon_e_b);
            end
        end
    end

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        if_a.rd_en = 1'b0; if_b.rd_en = 1'b0;
        tr_imm = '0; tr_rs = '0; tr_rd = '0; tr_f3 = '0; tr_op = 7'h13;
        last_exp = '0;
        repeat (3) tick();
        chk_status(0, "rst_a", 0, 0, 0, 0, 0, 0, 0);
        chk_status(1, "rst_b", 0, 0, 0, 0, 0, 0, 0);
        chk("rst_crn_a", 32'(crn_a), 32'd0);
        chk("rst_rd_valid_a", 32'(if_a.rd_valid), 32'd0);
        chk("rst_rd_data_a", if_a.rd_data, 32'd0);
        rst = 1'b1;
        tick();

        // Case 1: budget timeout on the default instance
        cur_depth = 8;
        do_run(0, 5, 0, 0, hi);
        chk("c1_crn_high_cycles", 32'(hi), 32'd5);
        chk("c1_crn_after", 32'(crn_a), 32'd0);
        chk_status(0, "c1", 1, 0, 1, 0, 5, 5, 0);
        repeat (2) tick();
        chk_status(0, "c1_hold", 1, 0, 1, 0, 5, 5, 0);
        repeat (5) pop_entry(0);
        tick();
        chk("c1_drained", 32'(if_a.trace_count), 32'd0);

        // Case 2: halt opcode on the 3rd RUN cycle
        do_run(0, 3, 3, 0, hi);
        chk("c2_crn_high_cycles", 32'(hi), 32'd3);
        chk_status(0, "c2", 1, 1, 0, 0, 3, 3, 0);
        repeat (3) pop_entry(0);
        tick();

        // Case 4: halt coincides with the last budgeted cycle
        do_run(0, 5, 5, 0, hi);
        chk_status(0, "c4", 1, 1, 0, 0, 5, 5, 0);

        // Case 5: asynchronous reset in RUN cycle 2, then a clean rerun
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        run_cycle(0, 1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("c5_crn", 32'(crn_a), 32'd0);
        chk("c5_running", 32'(run_a), 32'd0);
        chk("c5_trace_count", 32'(if_a.trace_count), 32'd0);
        chk("c5_cycle_count", 32'(cc_a), 32'd0);
        mdl.delete();
        tick();
        rst = 1'b1;
        tick();
        do_run(0, 5, 0, 0, hi);
        chk("c5_crn_high_cycles", 32'(hi), 32'd5);
        chk_status(0, "c5", 1, 0, 1, 0, 5, 5, 0);
        repeat (5) pop_entry(0);
        tick();

        // Case 3: 4-deep FIFO, 6 cycles, no reads -> overflow
        cur_depth = 4;
        do_run(1, 6, 0, 0, hi);
        chk("c3_crn_high_cycles", 32'(hi), 32'd6);
        chk_status(1, "c3", 1, 0, 1, 0, 6, 4, 1);
        repeat (4) pop_entry(1);
        pop_entry(1);
        chk("c3_drained", 32'(if_b.trace_count), 32'd0);

        // Case 6: full FIFO on the last RUN cycle with a coincident pop
        do_run(1, 5, 5, 5, hi);
        chk_status(1, "c6", 1, 1, 0, 0, 5, 4, 0);
        repeat (4) pop_entry(1);
        tick();
        tick();
        chk("sb_a_left", 32'(exp_a.size()), 32'd0);
        chk("sb_b_left", 32'(exp_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
